// File: rtl/mux_pkg.sv
// Shared types and helpers for the skid-buffered operand select.
package mux_pkg;

  localparam int unsigned MAX_N_IN = 16;

  // Number of beats held by the output stage.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  // Select width for n inputs, never narrower than one bit.
  function automatic int unsigned sel_w(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mux_sel_comb.sv
// Combinational N_IN:1 word select; codes at or above N_IN give zero and raise o_err_c.
module mux_sel_comb
  import mux_pkg::*;
#(
  parameter  int unsigned WIDTH = 16,
  parameter  int unsigned N_IN  = 3,
  localparam int unsigned SEL_W = sel_w(N_IN)
) (
  input  logic [N_IN*WIDTH-1:0] i_in_flat,
  input  logic [SEL_W-1:0]      i_set,
  output logic [WIDTH-1:0]      o_word_c,
  output logic                  o_err_c
);

  // Compare against every legal code so out-of-range selects never index past in_flat.
  always_comb begin
    o_word_c = '0;
    o_err_c  = 1'b1;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (i_set == SEL_W'(i)) begin
        o_word_c = i_in_flat[i*WIDTH +: WIDTH];
        o_err_c  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_skid_sel.sv
// Registered N_IN:1 operand select behind a valid/ready handshake with a 2-entry skid buffer.
// Define MUX_SKID_ERRCNT_EN to add the saturating err_cnt output.
module mux_skid_sel
  import mux_pkg::*;
#(
  parameter  int unsigned WIDTH = 16,
  parameter  int unsigned N_IN  = 3,
  localparam int unsigned SEL_W = sel_w(N_IN)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_IN*WIDTH-1:0] in_flat,
  input  logic [SEL_W-1:0]      set,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out,
  output logic                  out_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  err_sticky,
  input  logic                  err_clr
`ifdef MUX_SKID_ERRCNT_EN
  ,
  output logic [7:0]            err_cnt
`endif
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_main_data;
  logic             r_main_err;
  logic [WIDTH-1:0] r_skid_data;
  logic             r_skid_err;
  logic             r_out_valid;
  logic             r_in_ready;
  logic             r_err_sticky;

  logic [WIDTH-1:0] w_sel_word;
  logic             w_sel_err;
  logic             w_accept;
  logic             w_drain;
  logic             w_load_main;
  logic             w_load_skid;
  logic             w_skid_to_main;
  logic             w_err_accept;

  mux_sel_comb #(
    .WIDTH (WIDTH),
    .N_IN  (N_IN)
  ) u_sel (
    .i_in_flat (in_flat),
    .i_set     (set),
    .o_word_c  (w_sel_word),
    .o_err_c   (w_sel_err)
  );

  assign w_accept     = in_valid && r_in_ready;
  assign w_drain      = r_out_valid && out_ready;
  assign w_err_accept = w_accept && w_sel_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Occupancy transitions and the datapath load strobes they imply.
  always_comb begin
    w_state_nxt    = r_state;
    w_load_main    = 1'b0;
    w_load_skid    = 1'b0;
    w_skid_to_main = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_load_main = 1'b1;
          w_state_nxt = ONE;
        end
      end
      ONE: begin
        if (w_accept && !w_drain) begin
          w_load_skid = 1'b1;
          w_state_nxt = TWO;
        end else if (w_accept && w_drain) begin
          w_load_main = 1'b1;
        end else if (w_drain) begin
          w_state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (w_drain) begin
          w_skid_to_main = 1'b1;
          w_state_nxt    = ONE;
        end
      end
      default: begin
        w_state_nxt = EMPTY;
      end
    endcase
  end

  // Handshake flags track the next occupancy so both stay registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_main_data <= '0;
      r_main_err  <= 1'b0;
      r_skid_data <= '0;
      r_skid_err  <= 1'b0;
    end else begin
      r_out_valid <= (w_state_nxt != EMPTY);
      r_in_ready  <= (w_state_nxt != TWO);
      if (w_load_main) begin
        r_main_data <= w_sel_word;
        r_main_err  <= w_sel_err;
      end else if (w_skid_to_main) begin
        r_main_data <= r_skid_data;
        r_main_err  <= r_skid_err;
      end
      if (w_load_skid) begin
        r_skid_data <= w_sel_word;
        r_skid_err  <= w_sel_err;
      end
    end
  end

  // A new error beat outranks a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_sticky <= 1'b0;
    end else if (w_err_accept) begin
      r_err_sticky <= 1'b1;
    end else if (err_clr) begin
      r_err_sticky <= 1'b0;
    end
  end

`ifdef MUX_SKID_ERRCNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_cnt <= 8'd0;
    end else if (err_clr) begin
      r_err_cnt <= w_err_accept ? 8'd1 : 8'd0;
    end else if (w_err_accept && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

  assign in_ready   = r_in_ready;
  assign out        = r_main_data;
  assign out_err    = r_main_err;
  assign out_valid  = r_out_valid;
  assign err_sticky = r_err_sticky;

endmodule
